// File: rtl/sram_axi_pkg.sv
// sram_axi_slave shared types: FSM states, burst and response codes.
// Wrap bursts are built only when SRAM_AXI_WRAP_EN is defined.
package sram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_FETCH,
    ST_R_DATA,
    ST_W_DATA,
    ST_W_RESP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sram_axi_addr_gen.sv
// Next SRAM word address for the current beat of a burst.
// Wrap support is compiled in only with SRAM_AXI_WRAP_EN.
module sram_axi_addr_gen
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next
);

  logic [ADDR_W-1:0] w_inc;

  assign w_inc = i_addr + 1'b1;

`ifdef SRAM_AXI_WRAP_EN
  logic [ADDR_W-1:0] w_mask;
  logic              w_wrap_ok;

  assign w_mask    = ADDR_W'(i_len);
  assign w_wrap_ok = (i_len == 4'd1) || (i_len == 4'd3) ||
                     (i_len == 4'd7) || (i_len == 4'd15);

  // FIXED holds, aligned WRAP folds inside its block, else INCR
  always_comb begin
    o_next = w_inc;
    if (i_burst == BURST_FIXED)
      o_next = i_addr;
    else if (i_burst == BURST_WRAP && w_wrap_ok)
      o_next = (i_addr & ~w_mask) | (w_inc & w_mask);
  end
`else
  logic w_len_unused;

  assign w_len_unused = ^i_len;

  // FIXED holds, everything else increments
  always_comb begin
    o_next = w_inc;
    if (i_burst == BURST_FIXED)
      o_next = i_addr;
  end
`endif

endmodule

// File: rtl/sram_axi_slave.sv
// AXI4 slave port onto a single-port word SRAM, one burst at a time.
// Optional wrap bursts: define SRAM_AXI_WRAP_EN.
module sram_axi_slave
  import sram_axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [ID_W-1:0]   RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  input  logic [ID_W-1:0]   AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [3:0]        AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  output logic              SRAM_CEB,
  output logic [3:0]        SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DO
);

  state_t            r_state, w_state;
  logic [ID_W-1:0]   r_id;
  logic [3:0]        r_len, r_beat;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] r_addr, w_next;
  logic              r_err;
  logic              w_last;
  logic              w_aw_hs, w_ar_hs, w_r_hs, w_w_hs;
  logic              w_unused;

  assign w_unused = ^{ARSIZE_S, AWSIZE_S,
                      ARADDR_S[31:ADDR_W+2], ARADDR_S[1:0],
                      AWADDR_S[31:ADDR_W+2], AWADDR_S[1:0]};

  assign w_last  = (r_beat == r_len);
  assign w_aw_hs = AWVALID_S & AWREADY_S;
  assign w_ar_hs = ARVALID_S & ARREADY_S;
  assign w_r_hs  = RVALID_S & RREADY_S;
  assign w_w_hs  = WVALID_S & WREADY_S;

  sram_axi_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_addr  (r_addr),
    .i_len   (r_len),
    .i_burst (r_burst),
    .o_next  (w_next)
  );

  // FSM state register; reset drops any burst in flight
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state;
  end

  // Next state, AXI channel outputs and SRAM strobes
  always_comb begin
    w_state   = r_state;
    ARREADY_S = 1'b0;
    AWREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RDATA_S   = '0;
    RID_S     = '0;
    RRESP_S   = RESP_OKAY;
    RLAST_S   = 1'b0;
    WREADY_S  = 1'b0;
    BVALID_S  = 1'b0;
    BID_S     = '0;
    BRESP_S   = RESP_OKAY;
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 4'hF;
    SRAM_A    = '0;
    SRAM_DI   = '0;
    if (!ARESET) begin
      unique case (r_state)
        ST_IDLE: begin
          AWREADY_S = 1'b1;
          ARREADY_S = !AWVALID_S;
          if (AWVALID_S)      w_state = ST_W_DATA;
          else if (ARVALID_S) w_state = ST_R_FETCH;
        end
        ST_R_FETCH: begin
          SRAM_CEB = 1'b0;
          SRAM_A   = r_addr;
          w_state  = ST_R_DATA;
        end
        ST_R_DATA: begin
          RVALID_S = 1'b1;
          RDATA_S  = SRAM_DO;
          RID_S    = r_id;
          RLAST_S  = w_last;
          if (RREADY_S)
            w_state = w_last ? ST_IDLE : ST_R_FETCH;
        end
        ST_W_DATA: begin
          WREADY_S = 1'b1;
          if (WVALID_S) begin
            SRAM_CEB = 1'b0;
            SRAM_WEB = ~WSTRB_S;
            SRAM_DI  = WDATA_S;
            SRAM_A   = r_addr;
            if (WLAST_S) w_state = ST_W_RESP;
          end
        end
        ST_W_RESP: begin
          BVALID_S = 1'b1;
          BID_S    = r_id;
          BRESP_S  = r_err ? RESP_SLVERR : RESP_OKAY;
          if (BREADY_S) w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  // Burst context: latch on address handshake, step per beat
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_id    <= '0;
      r_len   <= '0;
      r_burst <= BURST_INCR;
      r_addr  <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else if (w_aw_hs) begin
      r_id    <= AWID_S;
      r_len   <= AWLEN_S;
      r_burst <= AWBURST_S;
      r_addr  <= AWADDR_S[ADDR_W+1:2];
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= ARID_S;
      r_len   <= ARLEN_S;
      r_burst <= ARBURST_S;
      r_addr  <= ARADDR_S[ADDR_W+1:2];
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else if (w_r_hs && !w_last) begin
      r_beat  <= r_beat + 1'b1;
      r_addr  <= w_next;
    end else if (w_w_hs) begin
      r_beat  <= r_beat + 1'b1;
      r_addr  <= w_next;
      r_err   <= r_err | (WLAST_S ? !w_last : w_last);
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Scoreboard bench for sram_axi_slave with a behavioural SRAM.
// Build with or without SRAM_AXI_WRAP_EN.
module tb_sram_axi_slave;
  import sram_axi_pkg::*;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [ID_W-1:0]   ARID_S = '0, AWID_S = '0;
  logic [31:0]       ARADDR_S = '0, AWADDR_S = '0;
  logic [3:0]        ARLEN_S = '0, AWLEN_S = '0;
  logic [2:0]        ARSIZE_S = 3'd2, AWSIZE_S = 3'd2;
  logic [1:0]        ARBURST_S = BURST_INCR, AWBURST_S = BURST_INCR;
  logic              ARVALID_S = 1'b0, AWVALID_S = 1'b0;
  logic              RREADY_S = 1'b1, BREADY_S = 1'b1;
  logic [31:0]       WDATA_S = '0;
  logic [3:0]        WSTRB_S = '0;
  logic              WLAST_S = 1'b0, WVALID_S = 1'b0;
  logic              ARREADY_S, AWREADY_S, WREADY_S;
  logic              RVALID_S, RLAST_S, BVALID_S;
  logic [ID_W-1:0]   RID_S, BID_S;
  logic [31:0]       RDATA_S;
  logic [1:0]        RRESP_S, BRESP_S;
  logic              SRAM_CEB;
  logic [3:0]        SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [31:0]       SRAM_DI;
  logic [31:0]       SRAM_DO = '0;

  sram_axi_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  function automatic logic [31:0] pat(int w);
    return 32'h5A00_0000 + 32'(w);
  endfunction

  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];

  // behavioural SRAM: 1-cycle read, output held until next access
  always @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
      mem[2] <= 32'h1122_3344;
    end else if (!SRAM_CEB) begin
      if (&SRAM_WEB) SRAM_DO <= mem[SRAM_A];
      else
        for (int b = 0; b < 4; b++)
          if (!SRAM_WEB[b]) mem[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]     d;
    logic            l;
    logic [ID_W-1:0] id;
  } rexp_t;
  typedef struct packed {
    logic [1:0]      r;
    logic [ID_W-1:0] id;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;
  int t_ar = 0;
  int r_last_cyc = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on every R and B handshake
  initial begin
    rexp_t e;
    bexp_t b;
    forever begin
      @(negedge ACLK);
      if (!ARESET && RVALID_S && RREADY_S) begin
        if (rq.size() == 0) check("r_unexp", RVALID_S, 1'b0);
        else begin
          e = rq.pop_front();
          check("rdata", RDATA_S, e.d);
          check("rlast", RLAST_S, e.l);
          check("rid", RID_S, e.id);
          check("rresp", RRESP_S, RESP_OKAY);
          if (RLAST_S) r_last_cyc = cyc;
        end
      end
      if (!ARESET && BVALID_S && BREADY_S) begin
        if (bq.size() == 0) check("b_unexp", BVALID_S, 1'b0);
        else begin
          b = bq.pop_front();
          check("bresp", BRESP_S, b.r);
          check("bid", BID_S, b.id);
        end
      end
    end
  end

  task automatic push_r(logic [7:0] id, int w, logic last);
    rq.push_back({shadow[w], last, id});
  endtask

  task automatic do_ar(logic [7:0] id, logic [31:0] a,
                       logic [3:0] len, logic [1:0] bu);
    int n = 0;
    ARID_S = id; ARADDR_S = a; ARLEN_S = len; ARBURST_S = bu;
    ARVALID_S = 1'b1;
    do begin @(negedge ACLK); n++; end
    while (!ARREADY_S && n < 50);
    check("ar_rdy", ARREADY_S, 1'b1);
    t_ar = cyc;
    @(posedge ACLK); #1 ARVALID_S = 1'b0;
  endtask

  task automatic do_aw(logic [7:0] id, logic [31:0] a,
                       logic [3:0] len, logic [1:0] bu);
    int n = 0;
    AWID_S = id; AWADDR_S = a; AWLEN_S = len; AWBURST_S = bu;
    AWVALID_S = 1'b1;
    do begin @(negedge ACLK); n++; end
    while (!AWREADY_S && n < 50);
    check("aw_rdy", AWREADY_S, 1'b1);
    @(posedge ACLK); #1 AWVALID_S = 1'b0;
  endtask

  task automatic wbeat(int w, logic [31:0] d, logic [3:0] s, logic last);
    int n = 0;
    WDATA_S = d; WSTRB_S = s; WLAST_S = last; WVALID_S = 1'b1;
    do begin @(negedge ACLK); n++; end
    while (!WREADY_S && n < 50);
    check("w_rdy", WREADY_S, 1'b1);
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
    @(posedge ACLK); #1 WVALID_S = 1'b0; WLAST_S = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() + bq.size()) != 0 && n < 200) begin
      @(negedge ACLK); n++;
    end
    check("drain", 64'(rq.size() + bq.size()), 0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
    shadow[2] = 32'h1122_3344;

    AWVALID_S = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst_awrdy", AWREADY_S, 1'b0);
    check("rst_arrdy", ARREADY_S, 1'b0);
    check("rst_rvalid", RVALID_S, 1'b0);
    check("rst_bvalid", BVALID_S, 1'b0);
    check("rst_wrdy", WREADY_S, 1'b0);
    check("rst_ceb", SRAM_CEB, 1'b1);
    check("rst_web", SRAM_WEB, 4'hF);
    check("rst_a", SRAM_A, 0);
    check("rst_rdata", RDATA_S, 0);
    AWVALID_S = 1'b0;
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_awrdy", AWREADY_S, 1'b1);
    @(posedge ACLK); #1;

    // 4-beat INCR line fill with latency checks
    for (int i = 0; i < 4; i++) push_r(8'h3C, 16 + i, i == 3);
    do_ar(8'h3C, 32'h40, 4'd3, BURST_INCR);
    @(negedge ACLK);
    check("r_fetch_nv", RVALID_S, 1'b0);
    @(negedge ACLK);
    check("r_first_v", RVALID_S, 1'b1);
    check("r_first_lat", 64'(cyc - t_ar), 2);
    drain();
    check("r_burst_lat", 64'(r_last_cyc - t_ar), 8);

    // byte-strobe write then read back
    bq.push_back({RESP_OKAY, 8'h21});
    do_aw(8'h21, 32'h8, 4'd0, BURST_INCR);
    wbeat(2, 32'hAABB_CCDD, 4'b0101, 1'b1);
    @(negedge ACLK);
    check("b_lat", BVALID_S, 1'b1);
    drain();
    rq.push_back({32'h11BB_33DD, 1'b1, 8'h22});
    do_ar(8'h22, 32'h8, 4'd0, BURST_INCR);
    drain();

    // simultaneous AW and AR: write goes first
    AWID_S = 8'h05; AWADDR_S = 32'h80; AWLEN_S = 4'd0;
    AWBURST_S = BURST_INCR; AWVALID_S = 1'b1;
    ARID_S = 8'h06; ARADDR_S = 32'h80; ARLEN_S = 4'd0;
    ARBURST_S = BURST_INCR; ARVALID_S = 1'b1;
    @(negedge ACLK);
    check("arb_awrdy", AWREADY_S, 1'b1);
    check("arb_arrdy", ARREADY_S, 1'b0);
    @(posedge ACLK); #1 AWVALID_S = 1'b0;
    bq.push_back({RESP_OKAY, 8'h05});
    wbeat(32, 32'h0BAD_F00D, 4'hF, 1'b1);
    @(negedge ACLK);
    check("arb_bvalid", BVALID_S, 1'b1);
    check("arb_arrdy_b", ARREADY_S, 1'b0);
    rq.push_back({32'h0BAD_F00D, 1'b1, 8'h06});
    @(posedge ACLK); #1;
    do_ar(8'h06, 32'h80, 4'd0, BURST_INCR);
    drain();

    // RREADY stall on beat 2
    for (int i = 0; i < 4; i++) push_r(8'h33, 48 + i, i == 3);
    do_ar(8'h33, 32'hC0, 4'd3, BURST_INCR);
    @(posedge ACLK);
    @(posedge ACLK); #1 RREADY_S = 1'b0;
    @(posedge ACLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("stl_rvalid", RVALID_S, 1'b1);
      check("stl_rdata", RDATA_S, shadow[49]);
      check("stl_rlast", RLAST_S, 1'b0);
      check("stl_ceb", SRAM_CEB, 1'b1);
    end
    @(posedge ACLK); #1 RREADY_S = 1'b1;
    drain();

    // early WLAST: 2 of 4 beats
    bq.push_back({RESP_SLVERR, 8'h44});
    do_aw(8'h44, 32'h100, 4'd3, BURST_INCR);
    wbeat(64, 32'hCAFE_0001, 4'hF, 1'b0);
    wbeat(65, 32'hCAFE_0002, 4'hF, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) push_r(8'h45, 64 + i, i == 3);
    do_ar(8'h45, 32'h100, 4'd3, BURST_INCR);
    drain();

    // beats past LEN still written
    bq.push_back({RESP_SLVERR, 8'h46});
    do_aw(8'h46, 32'h140, 4'd0, BURST_INCR);
    wbeat(80, 32'hBEEF_0001, 4'hF, 1'b0);
    wbeat(81, 32'hBEEF_0002, 4'hF, 1'b1);
    drain();
    push_r(8'h47, 80, 1'b0);
    push_r(8'h47, 81, 1'b1);
    do_ar(8'h47, 32'h140, 4'd1, BURST_INCR);
    drain();

    // WRAP burst
`ifdef SRAM_AXI_WRAP_EN
    push_r(8'h77, 18, 1'b0);
    push_r(8'h77, 19, 1'b0);
    push_r(8'h77, 16, 1'b0);
    push_r(8'h77, 17, 1'b1);
`else
    for (int i = 0; i < 4; i++) push_r(8'h77, 18 + i, i == 3);
`endif
    do_ar(8'h77, 32'h48, 4'd3, BURST_WRAP);
    drain();

    // FIXED burst
    for (int i = 0; i < 3; i++) push_r(8'h99, 5, i == 2);
    do_ar(8'h99, 32'h14, 4'd2, BURST_FIXED);
    drain();

    // reset mid-burst: no response afterwards
    do_ar(8'hAA, 32'h200, 4'd3, BURST_INCR);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_rst_rv", RVALID_S, 1'b0);
    check("mid_rst_ceb", SRAM_CEB, 1'b1);
    @(posedge ACLK); #1 ARESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check("post_rst_rv", RVALID_S, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
